// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: state encoding and opcode map.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD_IR = 3'd2,
        S_DECODE  = 3'd3,
        S_EXEC    = 3'd4,
        S_WRITE   = 3'd5,
        S_BRANCH  = 3'd6,
        S_HALT    = 3'd7
    } state_e;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_ALU_LO = 4'b0001;
    localparam logic [3:0] OP_ALU_HI = 4'b0111;
    localparam logic [3:0] OP_JMP    = 4'b1000;
    localparam logic [3:0] OP_BZ     = 4'b1001;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
    endfunction

endpackage

// File: rtl/fetch_sequencer_timeout_ctr.sv
// Counts idle FETCH cycles; tc_o flags the last permitted idle cycle before a fault.
module fetch_timeout_ctr #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [7:0] TC_VAL = 8'(WAIT_MAX - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // next count: clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM with registered Moore strobes.
// Optional macro SEQ_PERF_CNT_EN adds a 32-bit retired-instruction counter output.
module fetch_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] instr,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_rd,
    output logic              ir_load,
    output logic              pc_start,
    output logic              pc_enable,
    output logic              pc_branch,
    output logic              reg_out_en,
    output logic              alu_en,
    output logic              reg_wr,
    output logic              halted,
    output logic              fault
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       retired
`endif
);

    state_e     state_q, state_d;
    logic       pc_start_q, pc_start_d;
    logic       fault_q, fault_d;
    logic       mem_rd_q, ir_load_q, pc_enable_q, pc_branch_q;
    logic       reg_out_en_q, alu_en_q, reg_wr_q, halted_q;
    logic [3:0] opcode_s;
    logic       tmo_tc_s;
    logic       unused_instr_s;

    assign opcode_s       = instr[OPC_MSB:OPC_LSB];
    assign unused_instr_s = ^instr[OPC_LSB-1:0];

    fetch_timeout_ctr #(
        .WAIT_MAX (WAIT_MAX)
    ) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != S_FETCH),
        .en_i  ((state_q == S_FETCH) && !mem_ready),
        .tc_o  (tmo_tc_s)
    );

    // next-state decode; IDLE spends one extra cycle emitting pc_start
    always_comb begin
        state_d    = state_q;
        pc_start_d = 1'b0;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                if (pc_start_q) begin
                    state_d = S_FETCH;
                end else if (start) begin
                    pc_start_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_LOAD_IR;
                end else if (tmo_tc_s) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_LOAD_IR: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_s)
                    OP_JMP:  state_d = S_BRANCH;
                    OP_BZ:   state_d = zero ? S_BRANCH : S_FETCH;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = is_alu_op(opcode_s) ? S_EXEC : S_FETCH;
                endcase
            end
            S_EXEC:   state_d = S_WRITE;
            S_WRITE:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // state and strobes are registered from the next state so each output tracks its state exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_start_q   <= 1'b0;
            fault_q      <= 1'b0;
            mem_rd_q     <= 1'b0;
            ir_load_q    <= 1'b0;
            pc_enable_q  <= 1'b0;
            pc_branch_q  <= 1'b0;
            reg_out_en_q <= 1'b0;
            alu_en_q     <= 1'b0;
            reg_wr_q     <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_start_q   <= pc_start_d;
            fault_q      <= fault_d;
            mem_rd_q     <= (state_d == S_FETCH);
            ir_load_q    <= (state_d == S_LOAD_IR);
            pc_enable_q  <= (state_d == S_LOAD_IR);
            pc_branch_q  <= (state_d == S_BRANCH);
            reg_out_en_q <= (state_d == S_BRANCH);
            alu_en_q     <= (state_d == S_EXEC);
            reg_wr_q     <= (state_d == S_WRITE);
            halted_q     <= (state_d == S_HALT);
        end
    end

    assign mem_rd     = mem_rd_q;
    assign ir_load    = ir_load_q;
    assign pc_start   = pc_start_q;
    assign pc_enable  = pc_enable_q;
    assign pc_branch  = pc_branch_q;
    assign reg_out_en = reg_out_en_q;
    assign alu_en     = alu_en_q;
    assign reg_wr     = reg_wr_q;
    assign halted     = halted_q;
    assign fault      = fault_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_q;

    // count every decoded instruction except HALT; wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= 32'd0;
        end else if ((state_q == S_DECODE) && (opcode_s != OP_HALT)) begin
            retired_q <= retired_q + 32'd1;
        end else begin
            retired_q <= retired_q;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer plus hand sequences for timeout, HALT and reset.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, zero, mem_ready;
    logic [15:0] instr;
    logic        mem_rd, ir_load, pc_start, pc_enable, pc_branch;
    logic        reg_out_en, alu_en, reg_wr, halted, fault;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired;
`endif

    fetch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .ir_load    (ir_load),
        .pc_start   (pc_start),
        .pc_enable  (pc_enable),
        .pc_branch  (pc_branch),
        .reg_out_en (reg_out_en),
        .alu_en     (alu_en),
        .reg_wr     (reg_wr),
        .halted     (halted),
        .fault      (fault)
`ifdef SEQ_PERF_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    always #5 clk = ~clk;

    // bit order: mem_rd ir_load pc_start pc_enable pc_branch reg_out_en alu_en reg_wr halted fault
    localparam logic [9:0] O_NONE  = 10'b00_0000_0000;
    localparam logic [9:0] O_FETCH = 10'b10_0000_0000;
    localparam logic [9:0] O_LOAD  = 10'b01_0100_0000;
    localparam logic [9:0] O_PCST  = 10'b00_1000_0000;
    localparam logic [9:0] O_BR    = 10'b00_0011_0000;
    localparam logic [9:0] O_ALU   = 10'b00_0000_1000;
    localparam logic [9:0] O_WR    = 10'b00_0000_0100;
    localparam logic [9:0] O_HALT  = 10'b00_0000_0010;
    localparam logic [9:0] O_FAULT = 10'b00_0000_0011;

    logic [9:0] outv;
    assign outv = {mem_rd, ir_load, pc_start, pc_enable, pc_branch,
                   reg_out_en, alu_en, reg_wr, halted, fault};

    typedef struct {
        logic [15:0]      instr;
        logic             zero;
        logic             st;
        int               lat;
        logic [0:5][9:0]  exp;
    } vec_t;

    vec_t vecs [9];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // PC control strobes must stay mutually exclusive in every cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("inv_enable_branch", {31'd0, pc_enable & pc_branch}, 32'd0);
            chk("inv_start_pc", {31'd0, pc_start & (pc_enable | pc_branch)}, 32'd0);
        end
    end

    task automatic wait_fetch();
        for (int k = 0; k < 20 && !mem_rd; k++) @(negedge clk);
        chk("wait_fetch", {31'd0, mem_rd}, 32'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pc_start_pulse", {22'd0, outv}, {22'd0, O_PCST});
        @(negedge clk);
        chk("first_fetch", {22'd0, outv}, {22'd0, O_FETCH});
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        wait_fetch();
        instr = v.instr;
        zero  = v.zero;
        start = v.st;
        for (int off = 0; off <= v.lat; off++) begin
            if (off > 0) @(negedge clk);
            chk($sformatf("vec%0d_off%0d", idx, off), {22'd0, outv}, {22'd0, v.exp[off]});
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h0000, 1'b0, 1'b0, 3, {O_FETCH, O_LOAD, O_NONE, O_FETCH, O_NONE, O_NONE}};
        vecs[1] = '{16'h1234, 1'b0, 1'b1, 5, {O_FETCH, O_LOAD, O_NONE, O_ALU, O_WR, O_FETCH}};
        vecs[2] = '{16'h7FFF, 1'b1, 1'b0, 5, {O_FETCH, O_LOAD, O_NONE, O_ALU, O_WR, O_FETCH}};
        vecs[3] = '{16'h8000, 1'b0, 1'b0, 4, {O_FETCH, O_LOAD, O_NONE, O_BR, O_FETCH, O_NONE}};
        vecs[4] = '{16'h9000, 1'b1, 1'b0, 4, {O_FETCH, O_LOAD, O_NONE, O_BR, O_FETCH, O_NONE}};
        vecs[5] = '{16'h9000, 1'b0, 1'b0, 3, {O_FETCH, O_LOAD, O_NONE, O_FETCH, O_NONE, O_NONE}};
        vecs[6] = '{16'hA123, 1'b1, 1'b0, 3, {O_FETCH, O_LOAD, O_NONE, O_FETCH, O_NONE, O_NONE}};
        vecs[7] = '{16'hE000, 1'b0, 1'b0, 3, {O_FETCH, O_LOAD, O_NONE, O_FETCH, O_NONE, O_NONE}};
        vecs[8] = '{16'hF000, 1'b0, 1'b0, 3, {O_FETCH, O_LOAD, O_NONE, O_HALT, O_NONE, O_NONE}};

        rst = 1'b1; start = 1'b0; zero = 1'b0; mem_ready = 1'b1; instr = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset_outs", {22'd0, outv}, {22'd0, O_NONE});
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {22'd0, outv}, {22'd0, O_NONE});
        do_start();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // mem_ready arriving on the last permitted idle cycle is still accepted
        wait_fetch();
        instr = 16'h0000;
        mem_ready = 1'b0;
        repeat (14) @(negedge clk);
        chk("tmo_edge_fetch", {22'd0, outv}, {22'd0, O_FETCH});
        mem_ready = 1'b1;
        @(negedge clk);
        chk("tmo_edge_load", {22'd0, outv}, {22'd0, O_LOAD});

        // full timeout: 15 idle FETCH cycles -> fault + HALT
        wait_fetch();
        mem_ready = 1'b0;
        repeat (14) @(negedge clk);
        chk("tmo_last_fetch", {22'd0, outv}, {22'd0, O_FETCH});
        @(negedge clk);
        chk("tmo_fault", {22'd0, outv}, {22'd0, O_FAULT});
        start = 1'b1;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fault_ignores_start", {22'd0, outv}, {22'd0, O_FAULT});
        end
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_clears_fault", {22'd0, outv}, {22'd0, O_NONE});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_fault", {22'd0, outv}, {22'd0, O_NONE});
        do_start();

        // ten NOPs then HALT; outputs frozen afterwards
        for (int i = 0; i < 10; i++) run_vec(vecs[0], 100 + i);
        run_vec(vecs[8], 8);
`ifdef SEQ_PERF_CNT_EN
        chk("retired_count", retired, 32'd10);
`endif
        for (int k = 0; k < 20; k++) begin
            start = k[0];
            mem_ready = k[1];
            @(negedge clk);
            chk("halt_frozen", {22'd0, outv}, {22'd0, O_HALT});
        end
        start = 1'b0;
        mem_ready = 1'b1;

        // reset in the middle of EXEC aborts immediately
        do_reset();
        chk("idle_after_halt_rst", {22'd0, outv}, {22'd0, O_NONE});
        do_start();
        wait_fetch();
        instr = 16'h1234;
        repeat (3) @(negedge clk);
        chk("exec_before_rst", {22'd0, outv}, {22'd0, O_ALU});
        rst = 1'b1;
        #1;
        chk("rst_in_exec", {22'd0, outv}, {22'd0, O_NONE});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_exec_rst", {22'd0, outv}, {22'd0, O_NONE});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
